// File: rtl/rs_aged_pkg.sv
// rs_aged_pkg: shared constants (const_param) for the aged reservation station.
// No ports; the macros can be overridden by a project-wide definition set before this file.
`ifndef RS_SIZE
`define RS_SIZE 8
`endif
`ifndef RS_SIZE_WIDTH
`define RS_SIZE_WIDTH 3
`endif
`ifndef ROB_SIZE_WIDTH
`define ROB_SIZE_WIDTH 4
`endif
`ifndef CALC_OP_L1_NUM_WIDTH
`define CALC_OP_L1_NUM_WIDTH 4
`endif

package rs_aged_pkg;
    localparam int RS_SIZE              = `RS_SIZE;
    localparam int RS_SIZE_WIDTH        = `RS_SIZE_WIDTH;
    localparam int ROB_SIZE_WIDTH       = `ROB_SIZE_WIDTH;
    localparam int CALC_OP_L1_NUM_WIDTH = `CALC_OP_L1_NUM_WIDTH;
endpackage

// File: rtl/rs_aged_age_select.sv
// rs_age_select: DEPTH x DEPTH age matrix picking the oldest requesting entry.
// Ports: clk_in/rst_in clock and sync reset, en_in update enable,
//        alloc_in one-hot entry written this edge, req_in eligible entries,
//        grant_out one-hot oldest eligible entry (zero when none).
module rs_age_select
    import rs_aged_pkg::*;
#(
    parameter int DEPTH = RS_SIZE
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             en_in,
    input  logic [DEPTH-1:0] alloc_in,
    input  logic [DEPTH-1:0] req_in,
    output logic [DEPTH-1:0] grant_out
);
    // age_q[i][j] set means entry i was dispatched before entry j
    logic [DEPTH-1:0] age_q [DEPTH];
    logic [DEPTH-1:0] age_d [DEPTH];

    // a new entry is younger than everything, so stale bits of free entries never matter
    always_comb begin
        age_d = age_q;
        if (en_in)
            for (int i = 0; i < DEPTH; i++)
                for (int j = 0; j < DEPTH; j++)
                    if (alloc_in[j] && i != j) begin
                        age_d[i][j] = 1'b1;
                        age_d[j][i] = 1'b0;
                    end
    end

    always_comb begin
        grant_out = req_in;
        for (int i = 0; i < DEPTH; i++)
            for (int j = 0; j < DEPTH; j++)
                if (i != j && req_in[j] && age_q[j][i])
                    grant_out[i] = 1'b0;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in)
            for (int i = 0; i < DEPTH; i++)
                age_q[i] <= '0;
        else
            age_q <= age_d;
    end
endmodule

// File: rtl/rs_aged.sv
// rs_aged: reservation station with CDB wakeup and oldest-ready issue.
// Ports: clk_in/rst_in/rdy_in/flush_in control; cdb_* packed broadcast channels;
//        disp_* dispatch request; issue_ready_in/issue_* issue register handshake;
//        count_out occupancy, full_out combinational count_out == DEPTH.
module rs_aged
    import rs_aged_pkg::*;
#(
    parameter int DEPTH   = RS_SIZE,
    parameter int CDB_NUM = 2,
    parameter int ROB_W   = ROB_SIZE_WIDTH,
    parameter int OP_W    = CALC_OP_L1_NUM_WIDTH
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     flush_in,
    input  logic [CDB_NUM-1:0]       cdb_valid_in,
    input  logic [CDB_NUM*32-1:0]    cdb_value_in,
    input  logic [CDB_NUM*ROB_W-1:0] cdb_tag_in,
    input  logic                     disp_valid_in,
    input  logic [OP_W-1:0]          disp_op_l1_in,
    input  logic                     disp_op_l2_in,
    input  logic [31:0]              disp_v1_in,
    input  logic [31:0]              disp_v2_in,
    input  logic                     disp_q1_pend_in,
    input  logic                     disp_q2_pend_in,
    input  logic [ROB_W-1:0]         disp_q1_in,
    input  logic [ROB_W-1:0]         disp_q2_in,
    input  logic [ROB_W-1:0]         disp_rob_id_in,
    input  logic                     issue_ready_in,
    output logic                     issue_valid_out,
    output logic [OP_W-1:0]          issue_op_l1_out,
    output logic                     issue_op_l2_out,
    output logic [31:0]              issue_opr1_out,
    output logic [31:0]              issue_opr2_out,
    output logic [ROB_W-1:0]         issue_rob_id_out,
    output logic [$clog2(DEPTH):0]   count_out,
    output logic                     full_out
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int IW = $clog2(DEPTH);

    logic [DEPTH-1:0] valid_q, valid_d, p1_q, p1_d, p2_q, p2_d, l2_q, l2_d;
    logic [OP_W-1:0]  l1_q [DEPTH];
    logic [OP_W-1:0]  l1_d [DEPTH];
    logic [31:0]      v1_q [DEPTH];
    logic [31:0]      v1_d [DEPTH];
    logic [31:0]      v2_q [DEPTH];
    logic [31:0]      v2_d [DEPTH];
    logic [ROB_W-1:0] q1_q [DEPTH];
    logic [ROB_W-1:0] q1_d [DEPTH];
    logic [ROB_W-1:0] q2_q [DEPTH];
    logic [ROB_W-1:0] q2_d [DEPTH];
    logic [ROB_W-1:0] rob_q [DEPTH];
    logic [ROB_W-1:0] rob_d [DEPTH];
    logic             iv_q, iv_d, il2_q, il2_d;
    logic [OP_W-1:0]  il1_q, il1_d;
    logic [31:0]      io1_q, io1_d, io2_q, io2_d;
    logic [ROB_W-1:0] irob_q, irob_d;
    logic [CW-1:0]    count_q, count_d;
    logic [DEPTH-1:0] ready, grant, alloc;
    logic [IW-1:0]    gidx;
    logic             disp_acc, load, dp1, dp2;
    logic [31:0]      dv1, dv2;

    assign full_out = (count_q == CW'(DEPTH));
    assign ready    = valid_q & ~p1_q & ~p2_q;
    assign disp_acc = rdy_in && !flush_in && disp_valid_in && !full_out;
    assign load     = rdy_in && !flush_in && (!iv_q || issue_ready_in) && |grant;

    rs_age_select #(.DEPTH(DEPTH)) u_sel (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .en_in     (rdy_in),
        .alloc_in  (alloc & {DEPTH{disp_acc}}),
        .req_in    (ready),
        .grant_out (grant)
    );

    // lowest free entry and grant index; descending loops let the lowest match win
    always_comb begin
        alloc = '0;
        gidx  = '0;
        for (int i = DEPTH - 1; i >= 0; i--)
            if (!valid_q[i]) begin
                alloc    = '0;
                alloc[i] = 1'b1;
            end
        for (int i = 0; i < DEPTH; i++)
            if (grant[i])
                gidx = IW'(i);
    end

    // operands being dispatched can be satisfied by a broadcast in the same cycle
    always_comb begin
        dp1 = disp_q1_pend_in;
        dp2 = disp_q2_pend_in;
        dv1 = disp_v1_in;
        dv2 = disp_v2_in;
        for (int k = CDB_NUM - 1; k >= 0; k--)
            if (cdb_valid_in[k]) begin
                if (disp_q1_pend_in && disp_q1_in == cdb_tag_in[k*ROB_W +: ROB_W]) begin
                    dp1 = 1'b0;
                    dv1 = cdb_value_in[k*32 +: 32];
                end
                if (disp_q2_pend_in && disp_q2_in == cdb_tag_in[k*ROB_W +: ROB_W]) begin
                    dp2 = 1'b0;
                    dv2 = cdb_value_in[k*32 +: 32];
                end
            end
    end

    always_comb begin
        valid_d = valid_q;
        p1_d    = p1_q;
        p2_d    = p2_q;
        l2_d    = l2_q;
        l1_d    = l1_q;
        v1_d    = v1_q;
        v2_d    = v2_q;
        q1_d    = q1_q;
        q2_d    = q2_q;
        rob_d   = rob_q;
        if (rdy_in) begin
            for (int i = 0; i < DEPTH; i++)
                for (int k = CDB_NUM - 1; k >= 0; k--)
                    if (cdb_valid_in[k]) begin
                        if (p1_q[i] && q1_q[i] == cdb_tag_in[k*ROB_W +: ROB_W]) begin
                            p1_d[i] = 1'b0;
                            v1_d[i] = cdb_value_in[k*32 +: 32];
                        end
                        if (p2_q[i] && q2_q[i] == cdb_tag_in[k*ROB_W +: ROB_W]) begin
                            p2_d[i] = 1'b0;
                            v2_d[i] = cdb_value_in[k*32 +: 32];
                        end
                    end
            if (load)
                valid_d = valid_d & ~grant;
            if (disp_acc)
                for (int i = 0; i < DEPTH; i++)
                    if (alloc[i]) begin
                        valid_d[i] = 1'b1;
                        p1_d[i]    = dp1;
                        p2_d[i]    = dp2;
                        v1_d[i]    = dv1;
                        v2_d[i]    = dv2;
                        q1_d[i]    = disp_q1_in;
                        q2_d[i]    = disp_q2_in;
                        l1_d[i]    = disp_op_l1_in;
                        l2_d[i]    = disp_op_l2_in;
                        rob_d[i]   = disp_rob_id_in;
                    end
            if (flush_in)
                valid_d = '0;
        end
    end

    always_comb begin
        iv_d    = iv_q;
        il1_d   = il1_q;
        il2_d   = il2_q;
        io1_d   = io1_q;
        io2_d   = io2_q;
        irob_d  = irob_q;
        count_d = count_q;
        if (rdy_in) begin
            if (load) begin
                iv_d   = 1'b1;
                il1_d  = l1_q[gidx];
                il2_d  = l2_q[gidx];
                io1_d  = v1_q[gidx];
                io2_d  = v2_q[gidx];
                irob_d = rob_q[gidx];
            end else if (issue_ready_in)
                iv_d = 1'b0;
            count_d = flush_in ? '0 : count_q + CW'(disp_acc) - CW'(load);
            if (flush_in)
                iv_d = 1'b0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            valid_q <= '0;
            iv_q    <= 1'b0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            iv_q    <= iv_d;
            count_q <= count_d;
        end
        p1_q   <= p1_d;
        p2_q   <= p2_d;
        l2_q   <= l2_d;
        l1_q   <= l1_d;
        v1_q   <= v1_d;
        v2_q   <= v2_d;
        q1_q   <= q1_d;
        q2_q   <= q2_d;
        rob_q  <= rob_d;
        il1_q  <= il1_d;
        il2_q  <= il2_d;
        io1_q  <= io1_d;
        io2_q  <= io2_d;
        irob_q <= irob_d;
    end

    assign issue_valid_out  = iv_q;
    assign issue_op_l1_out  = il1_q;
    assign issue_op_l2_out  = il2_q;
    assign issue_opr1_out   = io1_q;
    assign issue_opr2_out   = io2_q;
    assign issue_rob_id_out = irob_q;
    assign count_out        = count_q;
endmodule

// File: tb/tb_rs_aged.sv
// tb_rs_aged: directed scenarios for rs_aged with hand-computed expectations.
module tb_rs_aged;
    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, flush_in;
    logic [1:0]  cdb_valid_in;
    logic [63:0] cdb_value_in;
    logic [7:0]  cdb_tag_in;
    logic        disp_valid_in, disp_op_l2_in, disp_q1_pend_in, disp_q2_pend_in;
    logic [3:0]  disp_op_l1_in, disp_q1_in, disp_q2_in, disp_rob_id_in;
    logic [31:0] disp_v1_in, disp_v2_in;
    logic        issue_ready_in, issue_valid_out, issue_op_l2_out, full_out;
    logic [3:0]  issue_op_l1_out, issue_rob_id_out, count_out;
    logic [31:0] issue_opr1_out, issue_opr2_out;
    int          cnt = 0;
    int          errs = 0;

    always #5 clk_in = ~clk_in;

    rs_aged dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
        .cdb_valid_in(cdb_valid_in), .cdb_value_in(cdb_value_in), .cdb_tag_in(cdb_tag_in),
        .disp_valid_in(disp_valid_in), .disp_op_l1_in(disp_op_l1_in), .disp_op_l2_in(disp_op_l2_in),
        .disp_v1_in(disp_v1_in), .disp_v2_in(disp_v2_in),
        .disp_q1_pend_in(disp_q1_pend_in), .disp_q2_pend_in(disp_q2_pend_in),
        .disp_q1_in(disp_q1_in), .disp_q2_in(disp_q2_in), .disp_rob_id_in(disp_rob_id_in),
        .issue_ready_in(issue_ready_in), .issue_valid_out(issue_valid_out),
        .issue_op_l1_out(issue_op_l1_out), .issue_op_l2_out(issue_op_l2_out),
        .issue_opr1_out(issue_opr1_out), .issue_opr2_out(issue_opr2_out),
        .issue_rob_id_out(issue_rob_id_out), .count_out(count_out), .full_out(full_out)
    );

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        rdy_in = 1'b1; flush_in = 1'b0; issue_ready_in = 1'b1;
        cdb_valid_in = '0; cdb_value_in = '0; cdb_tag_in = '0;
        disp_valid_in = 1'b0; disp_op_l1_in = '0; disp_op_l2_in = 1'b0;
        disp_v1_in = '0; disp_v2_in = '0; disp_q1_pend_in = 1'b0; disp_q2_pend_in = 1'b0;
        disp_q1_in = '0; disp_q2_in = '0; disp_rob_id_in = '0;
    endtask

    task automatic disp(input logic [3:0] rob, input logic [31:0] v1, input logic [31:0] v2,
                        input logic p1, input logic [3:0] q1, input logic p2, input logic [3:0] q2);
        disp_valid_in = 1'b1; disp_rob_id_in = rob; disp_op_l1_in = rob; disp_op_l2_in = rob[0];
        disp_v1_in = v1; disp_v2_in = v2;
        disp_q1_pend_in = p1; disp_q1_in = q1; disp_q2_pend_in = p2; disp_q2_in = q2;
    endtask

    task automatic cdb(input int ch, input logic [3:0] tag, input logic [31:0] val);
        cdb_valid_in[ch] = 1'b1;
        cdb_tag_in[ch*4 +: 4] = tag;
        cdb_value_in[ch*32 +: 32] = val;
    endtask

    task automatic test_reset();
        idle(); rst_in = 1'b1; rdy_in = 1'b0;
        step(); step();
        rst_in = 1'b0; rdy_in = 1'b1;
        cnt++; if (count_out !== 4'd0) begin errs++; $display("FAIL reset_count got %0d want 0", count_out); end
        cnt++; if (issue_valid_out !== 1'b0) begin errs++; $display("FAIL reset_iv got %b want 0", issue_valid_out); end
        cnt++; if (full_out !== 1'b0) begin errs++; $display("FAIL reset_full got %b want 0", full_out); end
    endtask

    task automatic test_basic();
        idle(); disp(4'd3, 32'd1, 32'd2, 1'b0, 4'd0, 1'b0, 4'd0);
        step();
        cnt++; if (count_out !== 4'd1 || issue_valid_out !== 1'b0) begin errs++; $display("FAIL basic_e1 got cnt=%0d iv=%b want cnt=1 iv=0", count_out, issue_valid_out); end
        disp(4'd5, 32'd3, 32'd4, 1'b0, 4'd0, 1'b0, 4'd0);
        step();
        cnt++; if ({issue_valid_out, issue_rob_id_out, issue_op_l1_out, issue_op_l2_out} !== {1'b1, 4'd3, 4'd3, 1'b1}) begin errs++; $display("FAIL basic_issue3 got iv=%b rob=%0d op=%0d/%b want 1 3 3/1", issue_valid_out, issue_rob_id_out, issue_op_l1_out, issue_op_l2_out); end
        cnt++; if (issue_opr1_out !== 32'd1 || issue_opr2_out !== 32'd2) begin errs++; $display("FAIL basic_opr3 got %0d %0d want 1 2", issue_opr1_out, issue_opr2_out); end
        cnt++; if (count_out !== 4'd1) begin errs++; $display("FAIL basic_cnt_e2 got %0d want 1", count_out); end
        disp_valid_in = 1'b0;
        step();
        cnt++; if (issue_valid_out !== 1'b1 || issue_rob_id_out !== 4'd5 || issue_opr2_out !== 32'd4) begin errs++; $display("FAIL basic_issue5 got iv=%b rob=%0d opr2=%0d want 1 5 4", issue_valid_out, issue_rob_id_out, issue_opr2_out); end
        cnt++; if (count_out !== 4'd0) begin errs++; $display("FAIL basic_cnt_e3 got %0d want 0", count_out); end
        step();
        cnt++; if (issue_valid_out !== 1'b0) begin errs++; $display("FAIL basic_drop got %b want 0", issue_valid_out); end
    endtask

    task automatic test_wakeup();
        idle(); disp(4'd1, 32'd0, 32'h11, 1'b1, 4'd7, 1'b0, 4'd0);
        step();
        disp(4'd2, 32'h22, 32'h23, 1'b0, 4'd0, 1'b0, 4'd0);
        step();
        cnt++; if (count_out !== 4'd2 || issue_valid_out !== 1'b0) begin errs++; $display("FAIL wake_e2 got cnt=%0d iv=%b want 2 0", count_out, issue_valid_out); end
        disp_valid_in = 1'b0; cdb(1, 4'd7, 32'hDEAD);
        step();
        cnt++; if (issue_valid_out !== 1'b1 || issue_rob_id_out !== 4'd2 || issue_opr1_out !== 32'h22) begin errs++; $display("FAIL wake_b_first got iv=%b rob=%0d opr1=%h want 1 2 22", issue_valid_out, issue_rob_id_out, issue_opr1_out); end
        cdb_valid_in = '0;
        step();
        cnt++; if (issue_valid_out !== 1'b1 || issue_rob_id_out !== 4'd1 || issue_opr1_out !== 32'hDEAD || issue_opr2_out !== 32'h11) begin errs++; $display("FAIL wake_a got iv=%b rob=%0d opr=%h/%h want 1 1 dead/11", issue_valid_out, issue_rob_id_out, issue_opr1_out, issue_opr2_out); end
        cnt++; if (count_out !== 4'd0) begin errs++; $display("FAIL wake_cnt got %0d want 0", count_out); end
        step();
    endtask

    task automatic test_cdb_priority();
        idle(); disp(4'd6, 32'h1, 32'h0, 1'b0, 4'd0, 1'b1, 4'd9);
        step();
        disp_valid_in = 1'b0; cdb(0, 4'd9, 32'hAAAA); cdb(1, 4'd9, 32'hBBBB);
        step();
        cdb_valid_in = '0;
        step();
        cnt++; if (issue_valid_out !== 1'b1 || issue_opr2_out !== 32'hAAAA) begin errs++; $display("FAIL cdb_prio got iv=%b opr2=%h want 1 aaaa", issue_valid_out, issue_opr2_out); end
        step();
    endtask

    task automatic test_disp_bypass();
        idle(); disp(4'd6, 32'h7, 32'h0, 1'b0, 4'd0, 1'b1, 4'd4); cdb(0, 4'd4, 32'h55);
        step();
        idle();
        cnt++; if (issue_valid_out !== 1'b0) begin errs++; $display("FAIL bypass_e1 got %b want 0", issue_valid_out); end
        step();
        cnt++; if (issue_valid_out !== 1'b1 || issue_opr2_out !== 32'h55 || issue_rob_id_out !== 4'd6) begin errs++; $display("FAIL bypass_e2 got iv=%b opr2=%h rob=%0d want 1 55 6", issue_valid_out, issue_opr2_out, issue_rob_id_out); end
        step();
    endtask

    task automatic test_age_order();
        idle(); disp(4'd1, 32'd0, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0);
        step();
        disp(4'd2, 32'd0, 32'd2, 1'b1, 4'd6, 1'b0, 4'd0);
        step();
        disp(4'd3, 32'd0, 32'd3, 1'b1, 4'd6, 1'b0, 4'd0);
        step();
        disp_valid_in = 1'b0; cdb(0, 4'd6, 32'h66);
        step();
        cdb_valid_in = '0;
        step();
        cnt++; if (issue_valid_out !== 1'b1 || issue_rob_id_out !== 4'd2 || issue_opr1_out !== 32'h66) begin errs++; $display("FAIL age_oldest got iv=%b rob=%0d opr1=%h want 1 2 66", issue_valid_out, issue_rob_id_out, issue_opr1_out); end
        step();
        cnt++; if (issue_valid_out !== 1'b1 || issue_rob_id_out !== 4'd3) begin errs++; $display("FAIL age_next got iv=%b rob=%0d want 1 3", issue_valid_out, issue_rob_id_out); end
        step();
    endtask

    task automatic test_full_hold_flush();
        idle();
        for (int i = 0; i < 8; i++) begin
            disp(4'(i), 32'd0, 32'(i), 1'b1, 4'd15, 1'b0, 4'd0);
            step();
            if (i == 6) begin
                cnt++; if (count_out !== 4'd7 || full_out !== 1'b0) begin errs++; $display("FAIL full_at7 got cnt=%0d full=%b want 7 0", count_out, full_out); end
            end
        end
        cnt++; if (count_out !== 4'd8 || full_out !== 1'b1) begin errs++; $display("FAIL full_at8 got cnt=%0d full=%b want 8 1", count_out, full_out); end
        disp(4'd9, 32'd0, 32'd9, 1'b0, 4'd0, 1'b0, 4'd0);
        step();
        cnt++; if (count_out !== 4'd8 || issue_valid_out !== 1'b0) begin errs++; $display("FAIL full_drop got cnt=%0d iv=%b want 8 0", count_out, issue_valid_out); end
        disp_valid_in = 1'b0; issue_ready_in = 1'b0; cdb(0, 4'd15, 32'h77);
        step();
        cdb_valid_in = '0;
        step();
        cnt++; if (issue_valid_out !== 1'b1 || issue_rob_id_out !== 4'd0 || issue_opr1_out !== 32'h77 || count_out !== 4'd7) begin errs++; $display("FAIL hold_load got iv=%b rob=%0d opr1=%h cnt=%0d want 1 0 77 7", issue_valid_out, issue_rob_id_out, issue_opr1_out, count_out); end
        for (int c = 0; c < 3; c++) begin
            step();
            cnt++; if ({issue_valid_out, issue_rob_id_out, issue_opr1_out, issue_opr2_out, count_out} !== {1'b1, 4'd0, 32'h77, 32'd0, 4'd7}) begin errs++; $display("FAIL hold_c%0d got iv=%b rob=%0d opr1=%h cnt=%0d want 1 0 77 7", c, issue_valid_out, issue_rob_id_out, issue_opr1_out, count_out); end
        end
        issue_ready_in = 1'b1;
        step();
        cnt++; if (issue_rob_id_out !== 4'd1 || issue_opr2_out !== 32'd1 || count_out !== 4'd6) begin errs++; $display("FAIL hold_release got rob=%0d opr2=%0d cnt=%0d want 1 1 6", issue_rob_id_out, issue_opr2_out, count_out); end
        step();
        cnt++; if (issue_valid_out !== 1'b1 || count_out !== 4'd5) begin errs++; $display("FAIL flush_pre got iv=%b cnt=%0d want 1 5", issue_valid_out, count_out); end
        flush_in = 1'b1; disp(4'd12, 32'd0, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0);
        step();
        cnt++; if (count_out !== 4'd0 || issue_valid_out !== 1'b0 || full_out !== 1'b0) begin errs++; $display("FAIL flush got cnt=%0d iv=%b full=%b want 0 0 0", count_out, issue_valid_out, full_out); end
        idle(); cdb(0, 4'd15, 32'h78);
        step();
        cdb_valid_in = '0;
        step(); step();
        cnt++; if (count_out !== 4'd0 || issue_valid_out !== 1'b0) begin errs++; $display("FAIL flush_after got cnt=%0d iv=%b want 0 0", count_out, issue_valid_out); end
    endtask

    task automatic test_freeze();
        idle(); disp(4'd10, 32'd0, 32'h10, 1'b1, 4'd3, 1'b0, 4'd0);
        step();
        disp(4'd11, 32'h31, 32'h32, 1'b0, 4'd0, 1'b0, 4'd0);
        step();
        rdy_in = 1'b0; disp(4'd13, 32'd0, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0); cdb(0, 4'd3, 32'h99);
        for (int c = 0; c < 4; c++) begin
            flush_in = (c == 2); issue_ready_in = c[0];
            step();
            cnt++; if (count_out !== 4'd2 || issue_valid_out !== 1'b0) begin errs++; $display("FAIL freeze_c%0d got cnt=%0d iv=%b want 2 0", c, count_out, issue_valid_out); end
        end
        idle();
        step();
        cnt++; if (issue_valid_out !== 1'b1 || issue_rob_id_out !== 4'd11 || count_out !== 4'd1) begin errs++; $display("FAIL resume got iv=%b rob=%0d cnt=%0d want 1 11 1", issue_valid_out, issue_rob_id_out, count_out); end
        cdb(0, 4'd3, 32'h99);
        step();
        cdb_valid_in = '0;
        cnt++; if (issue_valid_out !== 1'b0) begin errs++; $display("FAIL resume_gap got %b want 0", issue_valid_out); end
        step();
        cnt++; if (issue_valid_out !== 1'b1 || issue_rob_id_out !== 4'd10 || issue_opr1_out !== 32'h99 || count_out !== 4'd0) begin errs++; $display("FAIL resume_a got iv=%b rob=%0d opr1=%h cnt=%0d want 1 10 99 0", issue_valid_out, issue_rob_id_out, issue_opr1_out, count_out); end
        step();
    endtask

    task automatic test_reset_mid();
        idle(); disp(4'd1, 32'd0, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0);
        step();
        disp(4'd2, 32'd0, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0);
        step();
        idle(); rst_in = 1'b1; rdy_in = 1'b0;
        step();
        rst_in = 1'b0; rdy_in = 1'b1;
        cnt++; if (count_out !== 4'd0 || issue_valid_out !== 1'b0) begin errs++; $display("FAIL rst_mid got cnt=%0d iv=%b want 0 0", count_out, issue_valid_out); end
        step(); step();
        cnt++; if (count_out !== 4'd0 || issue_valid_out !== 1'b0) begin errs++; $display("FAIL rst_mid_after got cnt=%0d iv=%b want 0 0", count_out, issue_valid_out); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wakeup();
        test_cdb_priority();
        test_disp_bypass();
        test_age_order();
        test_full_hold_flush();
        test_freeze();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cnt, errs);
        $finish;
    end
endmodule
